// File: rtl/rst_req_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rst_req_ctrl                                                    |
// | Purpose  : Reset-request initiator. Turns a one-cycle control-plane        |
// |            request into a timed reset request toward the reset            |
// |            synchronizer. Confirms through the synchronizer's active-low   |
// |            feedback that reset was entered and then released, and         |
// |            reports completion (done pulse) or a sticky timeout.           |
// | Ports    : ref_clk_i   - sole clock                                        |
// |            rst_i       - synchronous active-high reset                     |
// |            req_i       - reset request, sampled only while req_ready_o=1  |
// |            req_ready_o - high in IDLE only                                 |
// |            arst_ni_fb  - asynchronous arst_no feedback (active-low)        |
// |            arst_req_o  - reset request to the synchronizer                 |
// |            busy_o      - high in every state except IDLE                   |
// |            done_o      - one-cycle pulse on successful completion          |
// |            timeout_o   - sticky error flag, cleared by next accepted req   |
// |            count_o     - saturating completed-reset counter                |
// | Config   : define RST_REQ_CNT_EN to build the 8-bit completion counter;    |
// |            otherwise count_o is tied to zero.                              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rst_req_ctrl #(
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       ref_clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  output logic       req_ready_o,
  input  logic       arst_ni_fb,
  output logic       arst_req_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       timeout_o,
  output logic [7:0] count_o
);

  localparam int c_HCNT_W = $clog2(HOLD_CYCLES) + 1;
  localparam int c_TCNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [c_HCNT_W-1:0] c_HOLD_LAST = c_HCNT_W'(HOLD_CYCLES - 1);
  localparam logic [c_TCNT_W-1:0] c_TMO_LAST  = c_TCNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ASSERT  = 3'd1,
    S_RELEASE = 3'd2,
    S_DONE    = 3'd3,
    S_ERR     = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_fb_sync;
  logic                   w_fb_s;
  logic [c_HCNT_W-1:0]    r_hcnt;
  logic [c_TCNT_W-1:0]    r_tcnt;
  logic                   r_seen_low;
  logic                   r_timeout;

  // Feedback synchronizer. Flops reset to 1 so a reset of this block never
  // looks like the downstream reset being active.
  always_ff @(posedge ref_clk_i) begin
    if (rst_i) begin
      r_fb_sync <= '1;
    end else begin
      r_fb_sync <= {r_fb_sync[SYNC_STAGES-2:0], arst_ni_fb};
    end
  end

  assign w_fb_s = r_fb_sync[SYNC_STAGES-1];

  // State register
  always_ff @(posedge ref_clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_next      = r_state;
    req_ready_o = 1'b0;
    arst_req_o  = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (req_i) begin
          w_next = S_ASSERT;
        end
      end
      S_ASSERT: begin
        arst_req_o = 1'b1;
        // Success wins over the timeout when both hold in the same cycle;
        // the live fb_s term lets a low seen this very cycle count.
        if (r_hcnt == c_HOLD_LAST && (r_seen_low || !w_fb_s)) begin
          w_next = S_RELEASE;
        end else if (r_tcnt == c_TMO_LAST) begin
          w_next = S_ERR;
        end
      end
      S_RELEASE: begin
        if (w_fb_s) begin
          w_next = S_DONE;
        end else if (r_tcnt == c_TMO_LAST) begin
          w_next = S_ERR;
        end
      end
      S_DONE: begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Hold/timeout counters, seen-low flag and sticky timeout flag
  always_ff @(posedge ref_clk_i) begin
    if (rst_i) begin
      r_hcnt     <= '0;
      r_tcnt     <= '0;
      r_seen_low <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_next != r_state) begin
        r_hcnt <= '0;
        r_tcnt <= '0;
      end else begin
        // Hold counter saturates so it can sit at its terminal value while
        // waiting for the feedback low to show up.
        if (r_state == S_ASSERT && r_hcnt != c_HOLD_LAST) begin
          r_hcnt <= r_hcnt + c_HCNT_W'(1);
        end
        if (r_state == S_ASSERT || r_state == S_RELEASE) begin
          r_tcnt <= r_tcnt + c_TCNT_W'(1);
        end
      end

      if (r_state == S_IDLE && req_i) begin
        r_seen_low <= 1'b0;
      end else if (r_state == S_ASSERT && !w_fb_s) begin
        r_seen_low <= 1'b1;
      end

      // Set on entry to ERR so the flag is visible while in ERR.
      if (r_state == S_IDLE && req_i) begin
        r_timeout <= 1'b0;
      end else if (w_next == S_ERR) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout_o = r_timeout;

`ifdef RST_REQ_CNT_EN
  logic [7:0] r_count;

  always_ff @(posedge ref_clk_i) begin
    if (rst_i) begin
      r_count <= 8'h00;
    end else if (r_state == S_DONE && r_count != 8'hFF) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign count_o = r_count;
`else
  assign count_o = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rst_req_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rst_req_ctrl                                                 |
// | Purpose  : Self-checking bench for rst_req_ctrl with a behavioural model   |
// |            of the reset synchronizer feedback and a scoreboard of expected |
// |            per-request outcomes.                                           |
// | Config   : honours RST_REQ_CNT_EN for the expected completion count.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_rst_req_ctrl;

  localparam int HOLD = 16;
  localparam int TMO  = 1024;
  localparam int SYNC = 2;

  // Feedback model modes
  localparam int c_FB_NOMINAL    = 0;
  localparam int c_FB_STUCK_HIGH = 1;
  localparam int c_FB_STUCK_LOW  = 2;

  typedef struct {
    int hi;     // cycles arst_req_o high
    int rel;    // busy cycles with arst_req_o low and no done (-1: don't care)
    int dones;  // done pulses
    bit tmo;    // timeout_o at end of request
    int cnt;    // count_o at end of request
  } exp_t;

  logic       clk;
  logic       rst;
  logic       req;
  logic       fb;
  logic       req_ready_o;
  logic       arst_req_o;
  logic       busy_o;
  logic       done_o;
  logic       timeout_o;
  logic [7:0] count_o;

  int   total;
  int   bad;
  int   fb_mode;
  int   cnt_model;
  exp_t sb[$];

  // Monitor state
  int   hi_len, rel_len, dones, last_hi, last_rel, last_dones, n_end;
  logic busy_q;

  rst_req_ctrl #(
    .HOLD_CYCLES   (HOLD),
    .TIMEOUT_CYCLES(TMO),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .ref_clk_i  (clk),
    .rst_i      (rst),
    .req_i      (req),
    .req_ready_o(req_ready_o),
    .arst_ni_fb (fb),
    .arst_req_o (arst_req_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .timeout_o  (timeout_o),
    .count_o    (count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int next_cnt(input int c);
`ifdef RST_REQ_CNT_EN
    return (c < 255) ? c + 1 : 255;
`else
    return 0;
`endif
  endfunction

  // Reset synchronizer model: drops feedback 3 cycles after the request
  // rises, restores it 4 cycles after the request falls.
  initial begin : fb_model
    int hi_c;
    int lo_c;
    hi_c = 0;
    lo_c = 0;
    fb   = 1'b1;
    forever begin
      @(negedge clk);
      if (arst_req_o === 1'b1) begin
        hi_c++;
        lo_c = 0;
      end else begin
        lo_c++;
        hi_c = 0;
      end
      if (arst_req_o === 1'b1 && hi_c >= 3 && fb_mode != c_FB_STUCK_HIGH) begin
        fb = 1'b0;
      end else if (arst_req_o !== 1'b1 && lo_c >= 4 && fb_mode == c_FB_NOMINAL) begin
        fb = 1'b1;
      end
    end
  end

  // Per-request measurements, sampled 1 time unit after each active edge
  initial begin : monitor
    busy_q     = 1'b0;
    hi_len     = 0;
    rel_len    = 0;
    dones      = 0;
    last_hi    = 0;
    last_rel   = 0;
    last_dones = 0;
    n_end      = 0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_o === 1'b1 && busy_q !== 1'b1) begin
        hi_len  = 0;
        rel_len = 0;
        dones   = 0;
      end
      if (busy_o === 1'b1) begin
        if (arst_req_o === 1'b1) hi_len++;
        else if (done_o !== 1'b1) rel_len++;
      end
      if (done_o === 1'b1) dones++;
      if (busy_o !== 1'b1 && busy_q === 1'b1) begin
        last_hi    = hi_len;
        last_rel   = rel_len;
        last_dones = dones;
        n_end++;
      end
      busy_q = busy_o;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_req();
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    int start;
    start = n_end;
    ok    = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (n_end != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One full request with the given feedback behaviour; outcome checked
  // against the scoreboard entry pushed when the request is driven.
  task automatic do_request(input int mode, input int exp_hi, input int exp_rel,
                            input int exp_dones, input bit exp_tmo);
    exp_t e;
    bit   ok;
    fb_mode = mode;
    e.hi    = exp_hi;
    e.rel   = exp_rel;
    e.dones = exp_dones;
    e.tmo   = exp_tmo;
    e.cnt   = (exp_dones > 0) ? next_cnt(cnt_model) : cnt_model;
    sb.push_back(e);
    pulse_req();
    wait_end(2200, ok);
    e = sb.pop_front();
    cnt_model = e.cnt;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL req_end: request did not finish, got busy=%b want busy=0", busy_o);
    end else begin
      total++;
      if (last_hi !== e.hi) begin
        bad++;
        $display("FAIL arst_len: got %0d want %0d", last_hi, e.hi);
      end
      if (e.rel >= 0) begin
        total++;
        if (last_rel !== e.rel) begin
          bad++;
          $display("FAIL release_len: got %0d want %0d", last_rel, e.rel);
        end
      end
      total++;
      if (last_dones !== e.dones) begin
        bad++;
        $display("FAIL done_pulses: got %0d want %0d", last_dones, e.dones);
      end
      total++;
      if (timeout_o !== e.tmo) begin
        bad++;
        $display("FAIL timeout_flag: got %b want %b", timeout_o, e.tmo);
      end
      total++;
      if (count_o !== 8'(e.cnt)) begin
        bad++;
        $display("FAIL count: got %0d want %0d", count_o, e.cnt);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (arst_req_o !== 1'b0)  begin bad++; $display("FAIL rst_arst_req: got %b want 0", arst_req_o); end
    total++; if (busy_o !== 1'b0)      begin bad++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    total++; if (done_o !== 1'b0)      begin bad++; $display("FAIL rst_done: got %b want 0", done_o); end
    total++; if (timeout_o !== 1'b0)   begin bad++; $display("FAIL rst_timeout: got %b want 0", timeout_o); end
    total++; if (count_o !== 8'h00)    begin bad++; $display("FAIL rst_count: got %0d want 0", count_o); end
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", req_ready_o); end
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(4);
  endtask

  task automatic test_nominal();
    // Immediate checks right after the accepting edge
    fork
      begin
        @(posedge clk);
        @(posedge clk);
        #1;
        total++;
        if (arst_req_o !== 1'b1 || busy_o !== 1'b1 || req_ready_o !== 1'b0) begin
          bad++;
          $display("FAIL accept_outputs: got arst=%b busy=%b ready=%b want 1 1 0",
                   arst_req_o, busy_o, req_ready_o);
        end
      end
    join_none
    // Request sampled at the second posedge from here; release phase lasts 6
    // cycles (4-cycle model delay + 2 synchronizer stages).
    do_request(c_FB_NOMINAL, HOLD, 6, 1, 1'b0);
    idle_cycles(2);
  endtask

  task automatic test_stuck_high();
    do_request(c_FB_STUCK_HIGH, TMO, 1, 0, 1'b1);
    fb_mode = c_FB_NOMINAL;
    idle_cycles(3);
    total++;
    if (busy_o !== 1'b0 || timeout_o !== 1'b1) begin
      bad++;
      $display("FAIL stuck_high_idle: got busy=%b timeout=%b want 0 1", busy_o, timeout_o);
    end
  endtask

  task automatic test_stuck_low();
    exp_t e;
    bit   ok;
    // RELEASE runs the full timeout, then one ERR cycle.
    do_request(c_FB_STUCK_LOW, HOLD, TMO + 1, 0, 1'b1);
    idle_cycles(5);
    total++;
    if (timeout_o !== 1'b1) begin
      bad++;
      $display("FAIL timeout_sticky: got %b want 1", timeout_o);
    end
    fb_mode = c_FB_NOMINAL;
    idle_cycles(8);
    e.hi = HOLD; e.rel = 6; e.dones = 1; e.tmo = 1'b0; e.cnt = next_cnt(cnt_model);
    sb.push_back(e);
    pulse_req();
    total++;
    if (timeout_o !== 1'b0) begin
      bad++;
      $display("FAIL timeout_clear: got %b want 0", timeout_o);
    end
    wait_end(200, ok);
    e = sb.pop_front();
    cnt_model = e.cnt;
    total++;
    if (!ok || last_dones !== e.dones || count_o !== 8'(e.cnt)) begin
      bad++;
      $display("FAIL clear_req: got end=%b dones=%0d count=%0d want 1 %0d %0d",
               ok, last_dones, count_o, e.dones, e.cnt);
    end
    idle_cycles(2);
  endtask

  task automatic test_busy_request();
    exp_t e;
    bit   ok;
    int   ends_before;
    e.hi = HOLD; e.rel = 6; e.dones = 1; e.tmo = 1'b0; e.cnt = next_cnt(cnt_model);
    sb.push_back(e);
    pulse_req();
    idle_cycles(3);
    pulse_req();   // lands 5 cycles into ASSERT
    wait_end(200, ok);
    e = sb.pop_front();
    cnt_model = e.cnt;
    total++;
    if (!ok || last_hi !== e.hi || last_dones !== e.dones) begin
      bad++;
      $display("FAIL busy_req_txn: got end=%b hi=%0d dones=%0d want 1 %0d %0d",
               ok, last_hi, last_dones, e.hi, e.dones);
    end
    total++;
    if (count_o !== 8'(e.cnt)) begin
      bad++;
      $display("FAIL busy_req_count: got %0d want %0d", count_o, e.cnt);
    end
    ends_before = n_end;
    idle_cycles(10);
    total++;
    if (busy_o !== 1'b0 || n_end != ends_before) begin
      bad++;
      $display("FAIL busy_req_queued: got busy=%b extra_ends=%0d want 0 0",
               busy_o, n_end - ends_before);
    end
  endtask

  task automatic test_midop_reset();
    exp_t e;
    fb_mode = c_FB_NOMINAL;
    e.hi = 8; e.rel = 0; e.dones = 0; e.tmo = 1'b0; e.cnt = 0;
    sb.push_back(e);
    pulse_req();
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    e = sb.pop_front();
    cnt_model = e.cnt;
    total++;
    if (arst_req_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL midop_outputs: got arst=%b busy=%b want 0 0", arst_req_o, busy_o);
    end
    total++;
    if (count_o !== 8'(e.cnt)) begin
      bad++;
      $display("FAIL midop_count: got %0d want %0d", count_o, e.cnt);
    end
    total++;
    if (last_hi !== e.hi || last_dones !== e.dones) begin
      bad++;
      $display("FAIL midop_hold: got hi=%0d dones=%0d want %0d %0d",
               last_hi, last_dones, e.hi, e.dones);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(10);
  endtask

  task automatic test_saturation();
    int want;
    for (int i = 0; i < 260; i++) begin
      do_request(c_FB_NOMINAL, HOLD, 6, 1, 1'b0);
    end
`ifdef RST_REQ_CNT_EN
    want = 255;
`else
    want = 0;
`endif
    total++;
    if (count_o !== 8'(want)) begin
      bad++;
      $display("FAIL saturation: got %0d want %0d", count_o, want);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    fb_mode   = c_FB_NOMINAL;
    cnt_model = 0;
    rst       = 1'b1;
    req       = 1'b0;
    test_reset();
    test_nominal();
    test_stuck_high();
    test_stuck_low();
    test_busy_request();
    test_midop_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rst_req_ctrl.md
# rst_req_ctrl

Reset-request initiator for the clock/reset generator. It turns a single-cycle request from the control plane into a timed `arst_req_i` assertion toward the reset synchronizer. It watches the synchronizer's `arst_no` feedback to confirm that reset was entered and then released, and reports completion or timeout. It sits in the `ref_clk_i` domain, upstream of the reset synchronizer that drives the clock mux/gate sub-top.

## Interface
Parameters:
- `HOLD_CYCLES`, 16: minimum cycles `arst_req_o` stays high (≥2).
- `TIMEOUT_CYCLES`, 1024: per-phase cycle limit for feedback to respond (> `HOLD_CYCLES`).
- `SYNC_STAGES`, 2: flop stages on the feedback synchronizer (≥2).

Ports:
- `ref_clk_i` in 1: sole clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_i` in 1: reset request; sampled only when `req_ready_o`=1.
- `req_ready_o` out 1: high in IDLE only.
- `arst_ni_fb` in 1: asynchronous `arst_no` feedback from the reset synchronizer (active-low).
- `arst_req_o` out 1: reset request to the synchronizer.
- `busy_o` out 1: high in any state except IDLE.
- `done_o` out 1: one-cycle pulse on successful completion.
- `timeout_o` out 1: sticky error flag.
- `count_o` out 8: completed-reset counter (see Configuration).

## Operation
- Feedback path: `arst_ni_fb` passes through `SYNC_STAGES` flops to give `fb_s`. All synchronizer flops reset to 1.
- States are IDLE, ASSERT, RELEASE, DONE, ERR.
- Two counters:
  - Hold counter `hcnt` (clog2(`HOLD_CYCLES`)+1 bits), saturates at `HOLD_CYCLES`-1.
  - Timeout counter `tcnt` (clog2(`TIMEOUT_CYCLES`)+1 bits).
  - Both clear on every state change.
- `seen_low` flag: set in ASSERT when `fb_s`=0; cleared on entry to ASSERT.
- IDLE: if `req_i` is high, go to ASSERT. The same edge clears `timeout_o`.
- ASSERT:
  - `arst_req_o`=1; `hcnt` and `tcnt` increment.
  - Exit to RELEASE when `hcnt`=`HOLD_CYCLES`-1 and `seen_low`=1 (or `fb_s`=0 this cycle).
  - Otherwise, when `tcnt`=`TIMEOUT_CYCLES`-1, go to ERR. The timeout check loses to the success condition in the same cycle.
- RELEASE:
  - `arst_req_o`=0; `tcnt` increments.
  - When `fb_s`=1, go to DONE.
  - When `tcnt`=`TIMEOUT_CYCLES`-1 with `fb_s`=0, go to ERR.
- DONE: `done_o`=1 for this one cycle; `count_o` increments, saturating at 255; go to IDLE.
- ERR: `arst_req_o`=0; `timeout_o` set; go to IDLE.
- `req_i` is ignored outside IDLE; requests are never queued.
- A feedback low outside ASSERT (e.g., a `glob_arst_ni` event) has no effect on state.

## Timing
- Reset values: state IDLE, `arst_req_o`=0, `busy_o`=0, `done_o`=0, `timeout_o`=0, `count_o`=0, `req_ready_o`=1.
- All outputs are registered or decoded from the state register; no combinational input-to-output path.
- `req_i` high at edge T starts the request:
  - `arst_req_o` is high from T+1.
  - `busy_o` is high from T+1.
  - `req_ready_o` is low from T+1.
- `arst_req_o` stays high for at least `HOLD_CYCLES` cycles.
- Minimum request-to-`done_o` latency is `HOLD_CYCLES` + `SYNC_STAGES` + 2 cycles, when feedback follows immediately.
- `rst_i` mid-operation: at the next edge, the block returns to reset values and `arst_req_o` drops.
- `rst_i` and `req_i` in the same cycle: `rst_i` wins.

## Configuration
- Macro `RST_REQ_CNT_EN`.
- Defined: the 8-bit saturating completion counter is built and drives `count_o`.
- Undefined: no counter flops; `count_o` is tied to 8'h00.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use `HOLD_CYCLES`=16, `TIMEOUT_CYCLES`=1024, `SYNC_STAGES`=2.
- Nominal: 1-cycle `req_i` pulse; the model drops `arst_ni_fb` 3 cycles after `arst_req_o` rises and restores it 4 cycles after `arst_req_o` falls. Required: `arst_req_o` high exactly 16 cycles, one `done_o` pulse, `count_o`=1, `timeout_o`=0.
- Stuck-high feedback: `arst_ni_fb` held at 1. Required: `arst_req_o` high 1024 cycles, then `timeout_o`=1, return to IDLE, no `done_o`, `count_o` unchanged.
- Stuck-low release: feedback never returns high. Required: `timeout_o` rises 1024 cycles after entering RELEASE. The next accepted `req_i` clears `timeout_o`.
- Busy request: `req_i` pulsed 5 cycles into ASSERT. Required: ignored, exactly one `done_o`, `count_o` +1.
- Mid-op reset: `rst_i` asserted at cycle 8 of ASSERT. Required: `arst_req_o`=0 and `busy_o`=0 on the next edge, `count_o`=0.
- Saturation: 260 nominal sequences. Required: `count_o`=255 with the macro defined, 0 without.
